ram_rd_streamer: RTL and testbench

// Read-side engine for ram_2clk_1w_1r. Takes a (start address, length) command
// and drains that many words from the RAM read port onto a valid/ready stream

---
 rtl/ram_rd_streamer_pkg.sv | 25 ++
 rtl/ram_rd_streamer_skid_buf2.sv | 60 ++++++
 rtl/ram_rd_streamer.sv | 112 +++++++++++
 tb/tb_ram_rd_streamer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_streamer_pkg.sv
// Shared types and helpers for the RAM read-side streamer.
// Holds the FSM encoding and the address-width helper used by the top and the bench.
package ram_rd_streamer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of address bits needed for `value` words, never less than 1.
    function automatic int clog2s(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_streamer_skid_buf2.sv
// Two-entry FIFO with registered head/valid outputs.
// Also used by the write-side streamer.
module stream_skid_buf2 #(
    parameter int C_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PUSH,
    input  logic [C_WIDTH-1:0] DIN,
    input  logic               POP,
    output logic [C_WIDTH-1:0] DOUT,
    output logic               VALID,
    output logic [1:0]         COUNT
);

    logic [C_WIDTH-1:0] head_q;
    logic [C_WIDTH-1:0] tail_q;
    logic [1:0]         count_q;
    logic [1:0]         count_nxt;
    logic               valid_q;
    logic               pop_ok;
    logic               push_ok;

    assign pop_ok    = POP && (count_q != 2'd0);
    assign push_ok   = PUSH && ((count_q != 2'd2) || pop_ok);
    assign count_nxt = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            valid_q <= (count_nxt != 2'd0);
            // head_q is always the oldest entry; tail_q only matters when two are held
            case (count_q)
                2'd0: begin
                    if (push_ok) head_q <= DIN;
                end
                2'd1: begin
                    if (push_ok && pop_ok) head_q <= DIN;
                    else if (push_ok)      tail_q <= DIN;
                end
                default: begin
                    if (pop_ok) begin
                        head_q <= tail_q;
                        if (push_ok) tail_q <= DIN;
                    end
                end
            endcase
        end
    end

    assign DOUT  = head_q;
    assign VALID = valid_q;
    assign COUNT = count_q;

endmodule

// File: rtl/ram_rd_streamer.sv
// Drains LEN words from a 1-cycle-latency RAM read port onto a valid/ready stream.
// Credit-limited prefetch into a 2-entry skid buffer keeps full throughput.
module ram_rd_streamer
    import ram_rd_streamer_pkg::*;
#(
    parameter int  C_RAM_WIDTH = 32,
    parameter int  C_RAM_DEPTH = 1024,
    parameter int  C_LEN_WIDTH = 16,
    localparam int AW          = clog2s(C_RAM_DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [AW-1:0]          START_ADDR,
    input  logic [C_LEN_WIDTH-1:0] LEN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [AW-1:0]          RD_ADDR,
    input  logic [C_RAM_WIDTH-1:0] RD_DATA,
    output logic [C_RAM_WIDTH-1:0] M_DATA,
    output logic                   M_VALID,
    output logic                   M_LAST,
    input  logic                   M_READY,
    output state_t                 DBG_STATE
);

    // Stream handshake: a beat transfers on a rising CLK edge where M_VALID and
    // M_READY are both high; once raised, M_VALID and its M_DATA/M_LAST hold
    // unchanged until that transfer happens.

    state_t                 state_q, state_nxt;
    logic [AW-1:0]          rd_addr_q;
    logic [C_LEN_WIDTH-1:0] issue_cnt_q;
    logic [C_LEN_WIDTH-1:0] beat_cnt_q;
    logic                   inflight_q;
    logic                   done_q;

    logic                   accept;
    logic                   handshake;
    logic                   last_beat;
    logic                   issue;
    logic [2:0]             credit_used;
    logic [1:0]             skid_count;
    logic                   skid_valid;
    logic [AW-1:0]          addr_next;

    assign accept      = (state_q == IDLE) && START && (LEN != '0);
    assign handshake   = skid_valid && M_READY;
    assign last_beat   = handshake && (beat_cnt_q == C_LEN_WIDTH'(1));
    // Entries held plus the read returning now, minus the one leaving this cycle.
    assign credit_used = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, handshake};
    assign issue       = (state_q == RUN) && (issue_cnt_q != '0) && (credit_used < 3'd2);
    assign addr_next   = (rd_addr_q == AW'(C_RAM_DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            inflight_q <= issue;
            done_q     <= last_beat;
            if (accept) begin
                rd_addr_q   <= START_ADDR;
                issue_cnt_q <= LEN;
                beat_cnt_q  <= LEN;
            end else begin
                if (issue) begin
                    rd_addr_q   <= addr_next;
                    issue_cnt_q <= issue_cnt_q - 1'b1;
                end
                if (handshake) begin
                    beat_cnt_q <= beat_cnt_q - 1'b1;
                end
            end
        end
    end

    stream_skid_buf2 #(
        .C_WIDTH (C_RAM_WIDTH)
    ) u_skid (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (inflight_q),
        .DIN   (RD_DATA),
        .POP   (handshake),
        .DOUT  (M_DATA),
        .VALID (skid_valid),
        .COUNT (skid_count)
    );

    assign M_VALID   = skid_valid;
    assign M_LAST    = skid_valid && (beat_cnt_q == C_LEN_WIDTH'(1));
    assign BUSY      = (state_q == RUN);
    assign DONE      = done_q;
    assign RD_ADDR   = rd_addr_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer: DEPTH=16 and DEPTH=12 instances, RAM holding data=addr.
// Table of commands plus hand sequences for LEN=0, reset abort and back-to-back.
module tb_ram_rd_streamer;
    import ram_rd_streamer_pkg::*;

    localparam int W  = 32;
    localparam int LW = 16;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    bit            use12 = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] len = '0;
    logic          m_ready = 1'b0;

    logic          start16, busy16, done16, m_valid16, m_last16;
    logic [AW-1:0] rd_addr16;
    logic [W-1:0]  rd_data16, m_data16;
    state_t        dbg16;
    logic          start12, busy12, done12, m_valid12, m_last12;
    logic [AW-1:0] rd_addr12;
    logic [W-1:0]  rd_data12, m_data12;
    state_t        dbg12;

    logic          busy, done, m_valid, m_last;
    logic [W-1:0]  m_data;
    logic [AW-1:0] rd_addr;
    state_t        dbg;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    assign start16 = start & ~use12;
    assign start12 = start & use12;
    assign busy    = use12 ? busy12    : busy16;
    assign done    = use12 ? done12    : done16;
    assign m_valid = use12 ? m_valid12 : m_valid16;
    assign m_last  = use12 ? m_last12  : m_last16;
    assign m_data  = use12 ? m_data12  : m_data16;
    assign rd_addr = use12 ? rd_addr12 : rd_addr16;
    assign dbg     = use12 ? dbg12     : dbg16;

    // RAM models: 1-cycle registered read, contents equal to the address.
    always @(posedge CLK) begin
        rd_data16 <= W'(rd_addr16);
        rd_data12 <= W'(rd_addr12);
    end

    ram_rd_streamer #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(16), .C_LEN_WIDTH(LW)) u_dut16 (
        .CLK(CLK), .RST(RST), .START(start16), .START_ADDR(start_addr), .LEN(len),
        .BUSY(busy16), .DONE(done16), .RD_ADDR(rd_addr16), .RD_DATA(rd_data16),
        .M_DATA(m_data16), .M_VALID(m_valid16), .M_LAST(m_last16), .M_READY(m_ready),
        .DBG_STATE(dbg16)
    );

    ram_rd_streamer #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(12), .C_LEN_WIDTH(LW)) u_dut12 (
        .CLK(CLK), .RST(RST), .START(start12), .START_ADDR(start_addr), .LEN(len),
        .BUSY(busy12), .DONE(done12), .RD_ADDR(rd_addr12), .RD_DATA(rd_data12),
        .M_DATA(m_data12), .M_VALID(m_valid12), .M_LAST(m_last12), .M_READY(m_ready),
        .DBG_STATE(dbg12)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Skid overflow / underflow watch on both instances.
    always @(posedge CLK) begin
        if (!RST) begin
            chk("skid16_overflow", W'(u_dut16.u_skid.PUSH && u_dut16.u_skid.COUNT == 2'd2 && !u_dut16.u_skid.POP), '0);
            chk("skid16_underflow", W'(u_dut16.u_skid.POP && u_dut16.u_skid.COUNT == 2'd0), '0);
            chk("skid12_overflow", W'(u_dut12.u_skid.PUSH && u_dut12.u_skid.COUNT == 2'd2 && !u_dut12.u_skid.POP), '0);
            chk("skid12_underflow", W'(u_dut12.u_skid.POP && u_dut12.u_skid.COUNT == 2'd0), '0);
        end
    end

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            start = 1'b0;
            chk("idle_busy", W'(busy), '0);
            chk("idle_valid", W'(m_valid), '0);
            chk("idle_done", W'(done), '0);
        end
    endtask

    // Entered at a negedge (cycle 0); returns at the negedge of the DONE cycle.
    task automatic run_cmd(input bit sel, input logic [AW-1:0] addr, input int n, input int pct,
                           input int exp_first, input int inject,
                           input logic [W-1:0] exp_first_d, input logic [W-1:0] exp_last_d);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_d;
        logic [W-1:0] held_d;
        logic         held_l;
        int depth;
        int cyc;
        int first_cyc;
        int done_cyc;
        int beats;
        bit last_hs;
        bit stalled;
        depth = sel ? 12 : 16;
        cyc = 0; first_cyc = -1; done_cyc = -1; beats = 0;
        last_hs = 1'b0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(W'((int'(addr) + i) % depth));
        use12 = sel;
        start = 1'b1;
        start_addr = addr;
        len = LW'(n);
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            start = (cyc == inject);
            if (cyc == inject) begin
                start_addr = 4'd9;
                len = LW'(3);
            end
            chk("busy", W'(busy), W'(!last_hs));
            chk("state", W'(dbg), last_hs ? W'(IDLE) : W'(RUN));
            chk("done", W'(done), W'(last_hs));
            if (last_hs) begin
                chk("valid_in_done_cycle", W'(m_valid), '0);
                done_cyc = cyc;
            end else begin
                if (stalled) begin
                    chk("stall_valid", W'(m_valid), 1);
                    chk("stall_data", m_data, held_d);
                    chk("stall_last", W'(m_last), W'(held_l));
                end
                m_ready = ($urandom_range(99) < pct);
                if (m_valid && first_cyc < 0) first_cyc = cyc;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", W'(1), '0);
                    end else begin
                        exp_d = exp_q.pop_front();
                        chk("beat_data", m_data, exp_d);
                        chk("beat_last", W'(m_last), W'(exp_q.size() == 0));
                        if (beats == 0) chk("first_data", m_data, exp_first_d);
                        if (exp_q.size() == 0) begin
                            chk("last_data", m_data, exp_last_d);
                            last_hs = 1'b1;
                        end
                        beats++;
                    end
                end
                stalled = m_valid && !m_ready;
                held_d = m_data;
                held_l = m_last;
            end
        end
        chk("cmd_completed", W'(done_cyc >= 0), 1);
        chk("beat_count", W'(beats), W'(n));
        if (exp_first >= 0) chk("first_valid_cycle", W'(first_cyc), W'(exp_first));
        if (exp_first >= 0 && pct == 100) chk("done_cycle", W'(done_cyc), W'(exp_first + n));
    endtask

    typedef struct {
        bit            sel12;
        logic [AW-1:0] addr;
        int            n;
        int            pct;
        int            exp_first;
        int            inject;
        logic [W-1:0]  exp_first_d;
        logic [W-1:0]  exp_last_d;
    } vec_t;

    vec_t vecs[6];
    int   rst_beats;

    initial begin
        vecs[0] = '{1'b0, 4'd2,  4, 100,  3, -1, 32'd2,  32'd5};
        vecs[1] = '{1'b0, 4'd14, 5, 100,  3, -1, 32'd14, 32'd2};
        vecs[2] = '{1'b1, 4'd10, 5, 100,  3, -1, 32'd10, 32'd2};
        vecs[3] = '{1'b0, 4'd5,  8, 40,  -1, -1, 32'd5,  32'd12};
        vecs[4] = '{1'b0, 4'd3,  6, 100,  3,  2, 32'd3,  32'd8};
        vecs[5] = '{1'b1, 4'd7,  9, 60,  -1, -1, 32'd7,  32'd3};

        @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            use12 = (s == 1);
            #1;
            chk("rst_busy", W'(busy), '0);
            chk("rst_done", W'(done), '0);
            chk("rst_valid", W'(m_valid), '0);
            chk("rst_last", W'(m_last), '0);
            chk("rst_data", m_data, '0);
            chk("rst_rd_addr", W'(rd_addr), '0);
        end
        use12 = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        idle_check(2);

        for (int v = 0; v < 6; v++) begin
            @(negedge CLK);
            run_cmd(vecs[v].sel12, vecs[v].addr, vecs[v].n, vecs[v].pct, vecs[v].exp_first,
                    vecs[v].inject, vecs[v].exp_first_d, vecs[v].exp_last_d);
            idle_check(3);
        end

        // LEN=0 is a no-op.
        use12 = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        start_addr = 4'd5;
        len = '0;
        idle_check(5);

        // Reset abort after three beats.
        @(negedge CLK);
        start = 1'b1;
        start_addr = 4'd0;
        len = LW'(8);
        m_ready = 1'b1;
        rst_beats = 0;
        for (int c = 0; c < 50 && rst_beats < 3; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (m_valid && m_ready) begin
                chk("pre_rst_beat", m_data, W'(rst_beats));
                rst_beats++;
            end
        end
        chk("pre_rst_beats", W'(rst_beats), 3);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_valid", W'(m_valid), '0);
        chk("abort_last", W'(m_last), '0);
        chk("abort_data", m_data, '0);
        chk("abort_rd_addr", W'(rd_addr), '0);
        @(negedge CLK);
        chk("abort_hold_valid", W'(m_valid), '0);
        RST = 1'b0;
        idle_check(3);
        @(negedge CLK);
        run_cmd(1'b0, 4'd0, 2, 100, 3, -1, 32'd0, 32'd1);
        idle_check(2);

        // Back-to-back: second START lands in the first command's DONE cycle.
        @(negedge CLK);
        run_cmd(1'b0, 4'd4, 3, 100, 3, -1, 32'd4, 32'd6);
        run_cmd(1'b0, 4'd12, 6, 100, 3, -1, 32'd12, 32'd1);
        idle_check(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: bench did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
